// File: rtl/mem_access_seq.sv
// mem_access_seq: sequencer for the LC3 memory-access stage.
// Takes one load/store request from execute, walks it through the indirect
// pointer, read and write phases (each held MEM_LAT cycles), then pulses done.
module mem_access_seq #(
   parameter int MEM_LAT = 1
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [2:0]  req_op,
   input  logic [15:0] req_addr,
   input  logic [15:0] req_data,
   output logic [1:0]  mem_state,
   output logic        m_control,
   output logic [15:0] m_addr,
   output logic [15:0] m_data,
   input  logic [15:0] memout,
   output logic        done,
   output logic [15:0] ld_data,
   output logic        err
);

   typedef enum logic [2:0] {
      OP_LD  = 3'd0,
      OP_LDR = 3'd1,
      OP_LDI = 3'd2,
      OP_ST  = 3'd3,
      OP_STR = 3'd4,
      OP_STI = 3'd5
   } op_t;

   typedef enum logic [2:0] {
      S_IDLE,
      S_IND,
      S_RD,
      S_WR,
      S_DONE
   } state_t;

   localparam logic [1:0] MS_READ = 2'd0;
   localparam logic [1:0] MS_IND  = 2'd1;
   localparam logic [1:0] MS_WRITE = 2'd2;
   localparam logic [1:0] MS_IDLE = 2'd3;

   localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT + 1) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(MEM_LAT - 1);

   state_t        state;
   state_t        next_state;
   logic [CW-1:0] cnt;
   logic [2:0]    op_q;
   logic [15:0]   addr_q;
   logic [15:0]   data_q;
   logic [15:0]   ptr_q;
   logic          last;
   logic          is_ind;
   logic          is_bad;
   logic          in_phase;
   logic [15:0]   eff_addr;

   assign last     = (cnt == CNT_LAST);
   assign is_ind   = (op_q == OP_LDI) || (op_q == OP_STI);
   assign is_bad   = op_q[2] & op_q[1];
   assign in_phase = (state == S_IND) || (state == S_RD) || (state == S_WR);
   assign eff_addr = is_ind ? ptr_q : addr_q;

   // State register; reset aborts any phase and returns to IDLE.
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state decode: accept routes by opcode, phases advance on their last cycle.
   always_comb begin
      next_state = state;
      case (state)
         S_IDLE: begin
            if (req_valid) begin
               case (req_op)
                  OP_LD, OP_LDR:  next_state = S_RD;
                  OP_LDI, OP_STI: next_state = S_IND;
                  OP_ST, OP_STR:  next_state = S_WR;
                  default:        next_state = S_DONE;
               endcase
            end
         end
         S_IND: begin
            if (last) begin
               next_state = (op_q == OP_LDI) ? S_RD : S_WR;
            end
         end
         S_RD: begin
            if (last) begin
               next_state = S_DONE;
            end
         end
         S_WR: begin
            if (last) begin
               next_state = S_DONE;
            end
         end
         S_DONE: begin
            next_state = S_IDLE;
         end
         default: begin
            next_state = S_IDLE;
         end
      endcase
   end

   // Request capture, phase counter, pointer and load-result registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         cnt     <= '0;
         op_q    <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         ptr_q   <= '0;
         ld_data <= '0;
      end else begin
         if (state == S_IDLE && req_valid) begin
            op_q   <= req_op;
            addr_q <= req_addr;
            data_q <= req_data;
         end
         if (in_phase && !last) begin
            cnt <= cnt + 1'b1;
         end else begin
            cnt <= '0;
         end
         if (state == S_IND && last) begin
            ptr_q <= memout;
         end
         if (state == S_RD && last) begin
            ld_data <= memout;
         end
      end
   end

   // Output decode: memory controls are a pure function of the current phase.
   always_comb begin
      req_ready = 1'b0;
      mem_state = MS_IDLE;
      m_control = 1'b0;
      m_addr    = '0;
      m_data    = '0;
      done      = 1'b0;
      err       = 1'b0;
      case (state)
         S_IDLE: begin
            req_ready = 1'b1;
         end
         S_IND: begin
            mem_state = MS_IND;
            m_addr    = addr_q;
         end
         S_RD: begin
            mem_state = MS_READ;
            m_control = is_ind;
            m_addr    = eff_addr;
         end
         S_WR: begin
            mem_state = MS_WRITE;
            m_control = is_ind;
            m_addr    = eff_addr;
            m_data    = data_q;
         end
         S_DONE: begin
            done = 1'b1;
            err  = is_bad;
         end
         default: begin
            mem_state = MS_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_mem_access_seq.sv
// tb_mem_access_seq: self-checking bench for mem_access_seq.
// Two instances (MEM_LAT=1 and MEM_LAT=3) share one bench memory; a
// transaction-level model predicts the per-cycle phase waveform and results.
module tb_mem_access_seq;

   logic clock = 1'b0;
   logic reset;

   logic        va, vb;
   logic [2:0]  opa, opb;
   logic [15:0] addra, addrb, dataa, datab;
   logic        rdya, rdyb;
   logic [1:0]  msa, msb;
   logic        mca, mcb;
   logic [15:0] maa, mab, mda, mdb, moa, mob, lda, ldb;
   logic        donea, doneb, erra, errb;

   logic [15:0] mem     [0:65535];
   logic [15:0] ref_mem [0:65535];
   logic [15:0] exp_ld  [2];

   int checks = 0;
   int errors = 0;

   logic        s_ready, s_mc, s_done, s_err;
   logic [1:0]  s_ms;
   logic [15:0] s_ma, s_md, s_ld;

   // Free-running clock, period 10.
   always #5 clock = ~clock;

   assign moa = mem[maa];
   assign mob = mem[mab];

   mem_access_seq #(.MEM_LAT(1)) dut_a (
      .clock(clock), .reset(reset), .req_valid(va), .req_ready(rdya),
      .req_op(opa), .req_addr(addra), .req_data(dataa), .mem_state(msa),
      .m_control(mca), .m_addr(maa), .m_data(mda), .memout(moa),
      .done(donea), .ld_data(lda), .err(erra)
   );

   mem_access_seq #(.MEM_LAT(3)) dut_b (
      .clock(clock), .reset(reset), .req_valid(vb), .req_ready(rdyb),
      .req_op(opb), .req_addr(addrb), .req_data(datab), .mem_state(msb),
      .m_control(mcb), .m_addr(mab), .m_data(mdb), .memout(mob),
      .done(doneb), .ld_data(ldb), .err(errb)
   );

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic sample(input int k);
      if (k == 0) begin
         s_ready = rdya; s_ms = msa; s_mc = mca; s_ma = maa;
         s_md = mda; s_done = donea; s_err = erra; s_ld = lda;
      end else begin
         s_ready = rdyb; s_ms = msb; s_mc = mcb; s_ma = mab;
         s_md = mdb; s_done = doneb; s_err = errb; s_ld = ldb;
      end
   endtask

   task automatic drive(input int k, input logic v, input logic [2:0] op,
                        input logic [15:0] addr, input logic [15:0] data);
      if (k == 0) begin
         va = v; opa = op; addra = addr; dataa = data;
      end else begin
         vb = v; opb = op; addrb = addr; datab = data;
      end
   endtask

   task automatic checkAll(input string tag, input logic ready, input logic [1:0] ms,
                           input logic mc, input logic [15:0] ma, input logic [15:0] md,
                           input logic dn, input logic er, input logic [15:0] ld);
      checkOutput({tag, ".req_ready"}, 32'(s_ready), 32'(ready));
      checkOutput({tag, ".mem_state"}, 32'(s_ms), 32'(ms));
      checkOutput({tag, ".m_control"}, 32'(s_mc), 32'(mc));
      checkOutput({tag, ".m_addr"}, 32'(s_ma), 32'(ma));
      checkOutput({tag, ".m_data"}, 32'(s_md), 32'(md));
      checkOutput({tag, ".done"}, 32'(s_done), 32'(dn));
      checkOutput({tag, ".err"}, 32'(s_err), 32'(er));
      checkOutput({tag, ".ld_data"}, 32'(s_ld), 32'(ld));
   endtask

   // One request from IDLE to the IDLE cycle after done. With hold set,
   // req_valid stays high and the next request's fields are presented at once.
   task automatic applyStimulus(input int k, input int lat, input string tag,
                                input logic [2:0] op, input logic [15:0] addr,
                                input logic [15:0] data, input logic hold,
                                input logic [2:0] nop, input logic [15:0] naddr,
                                input logic [15:0] ndata);
      logic        ill, ind, ldop, stop;
      logic [15:0] ea;
      int          nph, total, p;
      ill  = (op > 3'd5);
      ind  = (op == 3'd2) || (op == 3'd5);
      ldop = (op <= 3'd2);
      stop = (op >= 3'd3) && (op <= 3'd5);
      ea   = ind ? ref_mem[addr] : addr;
      nph  = ill ? 0 : (ind ? 2 : 1);
      total = nph * lat + 1;

      sample(k);
      checkAll({tag, ".idle"}, 1'b1, 2'd3, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, exp_ld[k]);
      drive(k, 1'b1, op, addr, data);
      @(posedge clock); #1;
      if (hold) drive(k, 1'b1, nop, naddr, ndata);
      else drive(k, 1'b0, 3'($urandom), 16'($urandom), 16'($urandom));

      for (int c = 1; c <= total; c++) begin
         if (c > 1) begin
            @(posedge clock); #1;
         end
         sample(k);
         if (c < total) begin
            if (s_ms === 2'd2) mem[s_ma] = s_md;
            p = (c - 1) / lat;
            if (ind && p == 0)
               checkAll($sformatf("%s.ind%0d", tag, c), 1'b0, 2'd1, 1'b0, addr, 16'h0, 1'b0, 1'b0, exp_ld[k]);
            else
               checkAll($sformatf("%s.ph%0d", tag, c), 1'b0, ldop ? 2'd0 : 2'd2, ind, ea,
                        stop ? data : 16'h0, 1'b0, 1'b0, exp_ld[k]);
         end else begin
            if (ldop) exp_ld[k] = ref_mem[ea];
            checkAll({tag, ".done"}, 1'b0, 2'd3, 1'b0, 16'h0, 16'h0, 1'b1, ill, exp_ld[k]);
         end
      end
      if (stop) ref_mem[ea] = data;
      @(posedge clock); #1;
      if (stop) checkOutput({tag, ".memwr"}, 32'(mem[ea]), 32'(data));
   endtask

   // Directed scenarios followed by randomized requests on both latencies.
   initial begin
      logic [2:0]  rop;
      logic [15:0] raddr, rdata;
      for (int i = 0; i < 65536; i++) begin
         mem[i] = 16'($urandom);
         ref_mem[i] = mem[i];
      end
      mem[16'h3000] = 16'hBEEF; ref_mem[16'h3000] = 16'hBEEF;
      mem[16'h3001] = 16'h4000; ref_mem[16'h3001] = 16'h4000;
      mem[16'h5000] = 16'hFFFF; ref_mem[16'h5000] = 16'hFFFF;
      mem[16'hFFFF] = 16'h00AA; ref_mem[16'hFFFF] = 16'h00AA;
      exp_ld[0] = 16'h0;
      exp_ld[1] = 16'h0;

      reset = 1'b1;
      drive(0, 1'b0, 3'd0, 16'h0, 16'h0);
      drive(1, 1'b0, 3'd0, 16'h0, 16'h0);
      repeat (2) @(posedge clock);
      #1;
      sample(0);
      checkAll("reset_a", 1'b1, 2'd3, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0);
      sample(1);
      checkAll("reset_b", 1'b1, 2'd3, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0);
      reset = 1'b0;

      $display("[TB] directed scenarios");
      applyStimulus(0, 1, "ld_beef", 3'd0, 16'h3000, 16'h0, 1'b0, 3'd0, 16'h0, 16'h0);
      checkOutput("ld_beef.value", 32'(lda), 32'h0000BEEF);
      applyStimulus(0, 1, "sti", 3'd5, 16'h3001, 16'h1234, 1'b0, 3'd0, 16'h0, 16'h0);
      checkOutput("sti.mem4000", 32'(mem[16'h4000]), 32'h00001234);
      applyStimulus(1, 3, "ldi_ffff", 3'd2, 16'h5000, 16'h0, 1'b0, 3'd0, 16'h0, 16'h0);
      checkOutput("ldi_ffff.value", 32'(ldb), 32'h000000AA);
      applyStimulus(0, 1, "illegal6", 3'd6, 16'h1111, 16'h2222, 1'b0, 3'd0, 16'h0, 16'h0);
      applyStimulus(1, 3, "illegal7", 3'd7, 16'h3333, 16'h4444, 1'b0, 3'd0, 16'h0, 16'h0);
      applyStimulus(0, 1, "b2b_1", 3'd3, 16'h6000, 16'hA5A5, 1'b1, 3'd4, 16'h6001, 16'h5A5A);
      applyStimulus(0, 1, "b2b_2", 3'd4, 16'h6001, 16'h5A5A, 1'b0, 3'd0, 16'h0, 16'h0);

      $display("[TB] reset during write phase");
      sample(1);
      checkAll("rst_pre", 1'b1, 2'd3, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, exp_ld[1]);
      drive(1, 1'b1, 3'd3, 16'h7000, 16'h5555);
      @(posedge clock); #1;
      drive(1, 1'b0, 3'd0, 16'h0, 16'h0);
      sample(1);
      checkOutput("rst_wr.mem_state", 32'(s_ms), 32'd2);
      reset = 1'b1;
      @(posedge clock); #1;
      exp_ld[0] = 16'h0;
      exp_ld[1] = 16'h0;
      sample(1);
      checkAll("rst_abort", 1'b1, 2'd3, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0);
      reset = 1'b0;
      @(posedge clock); #1;
      sample(1);
      checkAll("rst_after", 1'b1, 2'd3, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0);

      $display("[TB] randomized requests");
      for (int i = 0; i < 30; i++) begin
         rop = 3'($urandom_range(0, 7));
         raddr = 16'($urandom);
         rdata = 16'($urandom);
         applyStimulus(0, 1, $sformatf("rnd_a%0d", i), rop, raddr, rdata, 1'b0, 3'd0, 16'h0, 16'h0);
      end
      for (int i = 0; i < 20; i++) begin
         rop = 3'($urandom_range(0, 7));
         raddr = 16'($urandom);
         rdata = 16'($urandom);
         applyStimulus(1, 3, $sformatf("rnd_b%0d", i), rop, raddr, rdata, 1'b0, 3'd0, 16'h0, 16'h0);
      end
      sample(0);
      checkAll("final_a", 1'b1, 2'd3, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, exp_ld[0]);
      sample(1);
      checkAll("final_b", 1'b1, 2'd3, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, exp_ld[1]);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
